s38417_phase_arbiter: RTL and testbench

- Controller for the one-hot select lines that steer the s38417 phase-select compare cone (three mutually exclusive selects feeding the mux/compare network and its single result bit).
- Arbitrates among NREQ requesters and drives exactly one select per grant, with break-before-make.
- Holds the select for a settle window, then samples the cone result and reports it tagged with the requester ID.
- Keeps a saturating count of true results.

---
 rtl/s38417_phase_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_s38417_phase_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/s38417_phase_arbiter.sv
// rtl/s38417_phase_arbiter.sv - one-hot phase-select arbiter with settle/sample and match counter
//
// Purpose: grants one of NREQ requesters at a time, drives the matching
// one-hot select into the s38417 phase-select compare cone, holds it for
// HOLD settle cycles plus one sample cycle, then reports the cone result
// tagged with the requester index. Break-before-make is guaranteed by a
// mandatory RELEASE cycle with sel=0 between any two grants.
//
// Optional feature macro: S38417_PHASE_ARB_FIXED_PRIO_EN
//   defined   - fixed priority, lowest asserted request index wins
//   undefined - round-robin starting after the last granted index
//
// Ports:
//   CK           in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   enable       in   allows new grants (never aborts one in progress)
//   req          in   [NREQ-1:0] level-sensitive requests
//   cmp_in       in   compare cone result, used only in SAMPLE
//   sel          out  [NREQ-1:0] one-hot select, zero when not granting
//   gnt_id       out  [1:0] current or most recent grant index
//   busy         out  FSM not in IDLE
//   sample_valid out  one-cycle pulse qualifying sample_val/sample_id
//   sample_val   out  captured cmp_in
//   sample_id    out  [1:0] requester the sample belongs to
//   match_cnt    out  [CNTW-1:0] saturating count of samples equal to 1
module s38417_phase_arbiter #(
  parameter int NREQ = 3,
  parameter int HOLD = 2,
  parameter int CNTW = 8
) (
  input  logic            CK,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic            cmp_in,
  output logic [NREQ-1:0] sel,
  output logic [1:0]      gnt_id,
  output logic            busy,
  output logic            sample_valid,
  output logic            sample_val,
  output logic [1:0]      sample_id,
  output logic [CNTW-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SAMPLE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0]      HOLD_LOAD = 4'(HOLD - 1);
  localparam logic [NREQ-1:0] OH_LSB    = {{(NREQ-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [1:0]        gnt_id_q, gnt_id_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sample_valid_q, sample_valid_d;
  logic              sample_val_q, sample_val_d;
  logic [1:0]        sample_id_q, sample_id_d;
  logic [CNTW-1:0]   match_cnt_q, match_cnt_d;

  logic              found;
  logic [1:0]        pick_id;
  logic [NREQ-1:0]   pick_oh;
  int                idx;

  // Request selection
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    pick_oh = '0;
    idx     = 0;
`ifdef S38417_PHASE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        pick_id = 2'(i);
        pick_oh = OH_LSB << i;
      end
    end
`else
    // Scan starts one past the last granted index so every requester
    // gets a turn before any is served twice.
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_id = 2'(idx);
        pick_oh = OH_LSB << idx;
      end
    end
`endif
  end

  // Next-state and registered outputs
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    gnt_id_d       = gnt_id_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    sample_valid_d = 1'b0;
    sample_val_d   = sample_val_q;
    sample_id_d    = sample_id_q;
    match_cnt_d    = match_cnt_q;

    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (enable && found) begin
          state_d  = SETTLE;
          sel_d    = pick_oh;
          gnt_id_d = pick_id;
          ptr_d    = pick_id;
          cnt_d    = HOLD_LOAD;
        end
      end
      SETTLE: begin
        // sel_q is the one-hot of the granted index, so this tests req[gnt_id].
        if ((req & sel_q) == '0) begin
          state_d = RELEASE;
          sel_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        state_d        = RELEASE;
        sel_d          = '0;
        sample_valid_d = 1'b1;
        sample_val_d   = cmp_in;
        sample_id_d    = gnt_id_q;
        if (cmp_in && (match_cnt_q != {CNTW{1'b1}})) begin
          match_cnt_d = match_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // Mandatory dead cycle: keeps adjacent grants from driving
        // different selects on back-to-back cycles.
        state_d = IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      gnt_id_q       <= '0;
      ptr_q          <= 2'(NREQ - 1);
      cnt_q          <= '0;
      sample_valid_q <= 1'b0;
      sample_val_q   <= 1'b0;
      sample_id_q    <= '0;
      match_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      gnt_id_q       <= gnt_id_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      sample_valid_q <= sample_valid_d;
      sample_val_q   <= sample_val_d;
      sample_id_q    <= sample_id_d;
      match_cnt_q    <= match_cnt_d;
    end
  end

  assign sel          = sel_q;
  assign gnt_id       = gnt_id_q;
  assign busy         = (state_q != IDLE);
  assign sample_valid = sample_valid_q;
  assign sample_val   = sample_val_q;
  assign sample_id    = sample_id_q;
  assign match_cnt    = match_cnt_q;

endmodule

// File: tb/tb_s38417_phase_arbiter.sv
// tb/tb_s38417_phase_arbiter.sv - directed self-checking bench for s38417_phase_arbiter
module tb_s38417_phase_arbiter;

  logic       CK;
  logic       rst_n;
  logic       enable;
  logic [2:0] req;
  logic       cmp_in;
  logic [2:0] sel;
  logic [1:0] gnt_id;
  logic       busy;
  logic       sample_valid;
  logic       sample_val;
  logic [1:0] sample_id;
  logic [7:0] match_cnt;

  int checks = 0;
  int errors = 0;

  s38417_phase_arbiter #(.NREQ(3), .HOLD(2), .CNTW(8)) dut (
    .CK           (CK),
    .rst_n        (rst_n),
    .enable       (enable),
    .req          (req),
    .cmp_in       (cmp_in),
    .sel          (sel),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_val   (sample_val),
    .sample_id    (sample_id),
    .match_cnt    (match_cnt)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in IDLE; waits for the next grant and follows it through to IDLE.
  task automatic do_grant(input int exp_id, input logic exp_val, input int exp_wait);
    int waits;
    logic [31:0] oh;
    waits = 0;
    oh = 32'd1 << exp_id;
    while (sel === 3'b000 && waits < 20) begin
      tick();
      waits++;
    end
    check("grant_wait", waits, exp_wait);
    check("grant_sel", sel, oh);
    check("grant_id", gnt_id, exp_id);
    check("grant_busy", busy, 1);
    check("grant_nosv", sample_valid, 0);
    tick();
    check("settle2_sel", sel, oh);
    tick();
    check("sample_sel", sel, oh);
    tick();
    check("release_sel", sel, 0);
    check("release_sv", sample_valid, 1);
    check("release_sid", sample_id, exp_id);
    check("release_sval", sample_val, exp_val);
    tick();
    check("idle_sel", sel, 0);
    check("idle_sv", sample_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 3'b000;
    cmp_in = 1'b0;
    tick();
    tick();
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_sval", sample_val, 0);
    check("rst_sid", sample_id, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_mcnt", match_cnt, 0);

    // Single request, cmp=1
    rst_n  = 1'b1;
    enable = 1'b1;
    req    = 3'b001;
    cmp_in = 1'b1;
    do_grant(0, 1'b1, 1);
    check("t1_mcnt", match_cnt, 1);
    req = 3'b000;

    // All requesting: round-robin continues from pointer 0
    req    = 3'b111;
    cmp_in = 1'b0;
    do_grant(1, 1'b0, 1);
    do_grant(2, 1'b0, 1);
    do_grant(0, 1'b0, 1);
    do_grant(1, 1'b0, 1);
    check("t2_mcnt", match_cnt, 1);

    // Request drop during SETTLE
    req = 3'b010;
    tick();
    check("t3_sel", sel, 3'b010);
    req = 3'b000;
    tick();
    check("t3_drop_sel", sel, 0);
    check("t3_drop_sv", sample_valid, 0);
    check("t3_drop_busy", busy, 1);
    tick();
    check("t3_idle_sv", sample_valid, 0);
    check("t3_idle_busy", busy, 0);
    req    = 3'b111;
    cmp_in = 1'b1;
    do_grant(2, 1'b1, 1);
    check("t3_mcnt", match_cnt, 2);

    // Saturation: each grant with req held takes exactly 5 cycles
    req    = 3'b001;
    cmp_in = 1'b1;
    repeat (252 * 5) tick();
    check("t4_mcnt_254", match_cnt, 254);
    repeat (5) tick();
    check("t4_mcnt_255", match_cnt, 255);
    repeat (25) tick();
    check("t4_mcnt_sat", match_cnt, 255);

    // Reset during SAMPLE
    tick();
    tick();
    tick();
    check("t5_in_sample", sel, 3'b001);
    rst_n = 1'b0;
    tick();
    check("t5_rst_sel", sel, 0);
    check("t5_rst_sv", sample_valid, 0);
    check("t5_rst_mcnt", match_cnt, 0);
    check("t5_rst_busy", busy, 0);
    rst_n  = 1'b1;
    req    = 3'b111;
    cmp_in = 1'b0;
    do_grant(0, 1'b0, 1);
    check("t5_mcnt", match_cnt, 0);

    // req=110 repeated
    req = 3'b110;
`ifdef S38417_PHASE_ARB_FIXED_PRIO_EN
    do_grant(1, 1'b0, 1);
    do_grant(1, 1'b0, 1);
    do_grant(1, 1'b0, 1);
`else
    do_grant(1, 1'b0, 1);
    do_grant(2, 1'b0, 1);
    do_grant(1, 1'b0, 1);
`endif

    // enable dropped mid-grant: grant completes, then no new grant
    req = 3'b001;
    tick();
    check("t7_sel", sel, 3'b001);
    enable = 1'b0;
    tick();
    tick();
    tick();
    check("t7_release_sv", sample_valid, 1);
    check("t7_release_sel", sel, 0);
    tick();
    check("t7_idle_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t7_hold_sel", sel, 0);
      check("t7_hold_busy", busy, 0);
    end
    enable = 1'b1;
    tick();
    check("t7_regrant", sel, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
